ifetch_stage: RTL and testbench
===============================

// Module: ifetch_stage
// PURPOSE
//   Instruction-fetch stage directly upstream of the byte-addressed IMEM; IMEM read is combinational, assembled little-endian.
//   Owns the fetch PC and drives it to IMEM; samples the returned word the same cycle.
//   Buffers fetched {pc, instr} pairs in a small FIFO.
//   Presents them to decode over a valid/ready handshake; accepts branch/jump redirects with flush.
// PARAMETERS
//   RESET_PC    32'h0000_0000  fetch PC loaded on reset
//   FQ_DEPTH    2              fetch-queue entries (power of 2, >=2)
// PORTS
//   clk             in   1   single clock, rising edge
//   rst_n           in   1   reset, synchronous, active-low
//   imem_pc         out  32  byte address to IMEM (= fetch PC register)
//   imem_instr      in   32  IMEM read data for imem_pc, valid same cycle
//   redirect_valid  in   1   flush + load new fetch PC
//   redirect_pc     in   32  redirect target
//   id_valid        out  1   queue head valid toward decode
//   id_ready        in   1   decode accepts head
//   id_instr        out  32  head instruction
//   id_pc           out  32  head PC
//   id_pc_plus4     out  32  head PC + 4 (mod 2^32)
//   id_misalign     out  1   only with IFETCH_MISALIGN_TRAP_EN: head fetch was misaligned
// BEHAVIOUR
//   Reset (rst_n=0 at edge):
//     - fetch PC <= RESET_PC; queue emptied; count=0.
//     - id_valid=0; id_instr=32'h0000_0013 (NOP) whenever empty.
//     - id_pc=0 and id_pc_plus4=4 whenever empty.
//   pop  = id_valid & id_ready.
//   push = ~redirect_valid & (count<FQ_DEPTH | pop) [& ~halted, macro only].
//     - Entry pushed = {imem_pc, imem_instr}.
//   On push: fetch PC <= fetch PC + 4.
//     - Wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//   Full queue with pop: push and pop occur on the same edge; count unchanged.
//   Empty queue: pop impossible, since id_valid=0.
//   Redirect (edge N):
//     - Queue flushed and count=0; fetch PC <= redirect_pc; no push at edge N.
//     - A pop in the same cycle still counts as consumed by decode; flush overrides it.
//     - Target entry pushed at edge N+1; id_valid=1 after edge N+1.
//     - Redirect penalty is therefore one empty cycle.
//   Back-to-back redirects: the last one wins; no push on any redirect cycle.
//   Latency: reset released before edge 0 -> RESET_PC entry is valid at decode after edge 0.
//     - Steady state: 1 instruction/cycle when id_ready=1.
//   id_valid is registered, i.e. derived from count.
//   id_* are driven from the queue head register array (no combinational path from imem_instr).
//   Reset mid-operation overrides redirect and the handshake; state is identical to power-up reset.
// CONFIGURATION
//   IFETCH_MISALIGN_TRAP_EN defined:
//     - If fetch PC[1:0]!=0, push an entry with id_misalign=1 and id_instr=NOP, then set halted.
//     - While halted: no further pushes; PC frozen.
//     - halted is cleared only by a redirect or reset.
//   IFETCH_MISALIGN_TRAP_EN undefined:
//     - Fetch PC[1:0] is forced to 2'b00 on redirect load; no id_misalign port.
//     - No halted state.
// TESTING
//   1. Reset, RESET_PC=0, id_ready=1, IMEM program:
//        NOP, 0x00400093, 0x00100113.
//      -> Edges 0,1,2 present id_pc 0,4,8 with those instrs.
//      -> id_pc_plus4 4,8,12.
//   2. id_ready=0 for 5 cycles:
//      -> count saturates at FQ_DEPTH; imem_pc holds at 8.
//      -> Release: in-order pcs 0,4,8 with no gap, no loss, no duplication.
//   3. Redirect to 0x3C while 2 entries are queued:
//      -> The next cycle has id_valid=0.
//      -> The following cycle shows id_pc=0x3C, id_instr=0x40475793.
//   4. Redirect to 0xFFFF_FFFC, id_ready=1:
//      -> id_pc sequence 0xFFFF_FFFC, 0x0000_0000.
//      -> id_pc_plus4 of the first is 0.
//   5. Assert rst_n=0 for one edge mid-stream with a full queue:
//      -> id_valid=0, imem_pc=RESET_PC next cycle.
//      -> Refetch restarts from RESET_PC.
//   6. Redirect to 0x06:
//      -> With the macro: one entry with id_misalign=1 and id_instr=NOP; then no push until a redirect to 0x10 resumes.
//      -> Without the macro: fetch resumes at 0x04.

Source files
------------

// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction-fetch stage with a small {pc, instr} queue to decode.
// The IMEM read is combinational: the word for imem_pc is sampled in the same cycle.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN
//   defined   -> a misaligned fetch PC pushes one flagged NOP entry and then halts fetch
//   undefined -> redirect targets are word-aligned on load; no id_misalign port
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        id_misalign
`endif
);

  localparam int          PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // Fetch PC and queue bookkeeping
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Queue storage
  logic [31:0] fq_pc_q    [FQ_DEPTH];
  logic [31:0] fq_instr_q [FQ_DEPTH];

  logic        full;
  logic        pop;
  logic        push;
  logic [31:0] push_instr;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;
  logic misaligned;
  logic fq_mis_q [FQ_DEPTH];

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign push_instr = misaligned ? NOP : imem_instr;
`else
  assign push_instr = imem_instr;
`endif

  assign full = (count_q == CNT_W'(FQ_DEPTH));
  assign pop  = id_valid & id_ready;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign push = ~redirect_valid & (~full | pop) & ~halted_q;
`else
  assign push = ~redirect_valid & (~full | pop);
`endif

  // Next-state logic for fetch PC, pointers, occupancy (and halt flag)
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    halted_d = halted_q;
`endif
    if (redirect_valid) begin
      // Flush wins over any same-cycle pop; the target is fetched next cycle.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      pc_d     = redirect_pc;
      halted_d = 1'b0;
`else
      pc_d     = redirect_pc & ~32'h0000_0003;
`endif
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
`ifdef IFETCH_MISALIGN_TRAP_EN
        if (misaligned) halted_d = 1'b1;
        else            pc_d     = pc_q + 32'd4;
`else
        pc_d = pc_q + 32'd4;
`endif
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted_q <= halted_d;
`endif
    end
  end

  // Queue storage write on push
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
    if (push) begin
      fq_pc_q[wr_ptr_q]    <= pc_q;
      fq_instr_q[wr_ptr_q] <= push_instr;
`ifdef IFETCH_MISALIGN_TRAP_EN
      fq_mis_q[wr_ptr_q]   <= misaligned;
`endif
    end
  end

  // Decode-facing outputs come only from registered queue state
  assign imem_pc     = pc_q;
  assign id_valid    = (count_q != '0);
  assign id_instr    = id_valid ? fq_instr_q[rd_ptr_q] : NOP;
  assign id_pc       = id_valid ? fq_pc_q[rd_ptr_q] : 32'h0000_0000;
  assign id_pc_plus4 = id_pc + 32'd4;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign id_misalign = id_valid & fq_mis_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed stimulus with a scoreboard queue of expected decode entries;
// a negedge monitor pops and compares every accepted handshake.
module tb_ifetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        id_misalign;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] plus4;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ifetch_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    .id_misalign    (id_misalign)
`endif
  );

  // IMEM contents: small program plus a recognisable filler pattern
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'h0040_0093;
      32'h0000_0008: return 32'h0010_0113;
      32'h0000_003C: return 32'h4047_5793;
      default:       return 32'hC000_0000 ^ a;
    endcase
  endfunction

  always_comb imem_instr = imem_word(imem_pc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] plus4, input logic mis);
    exp_t e;
    e.pc = pc; e.instr = instr; e.plus4 = plus4; e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake that will complete at the next edge is compared in order
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected no entry", id_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", id_pc, e.pc);
        check("pop_instr", id_instr, e.instr);
        check("pop_pc_plus4", id_pc_plus4, e.plus4);
`ifdef IFETCH_MISALIGN_TRAP_EN
        check("pop_misalign", {31'd0, id_misalign}, {31'd0, e.mis});
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(2);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_instr", id_instr, NOP);
    check("rst_pc", id_pc, 32'h0);
    check("rst_pc_plus4", id_pc_plus4, 32'h4);
    check("rst_imem_pc", imem_pc, 32'h0);

    // Straight-line fetch with decode always ready
    expect_entry(32'h0, NOP,           32'h4, 1'b0);
    expect_entry(32'h4, 32'h0040_0093, 32'h8, 1'b0);
    expect_entry(32'h8, 32'h0010_0113, 32'hC, 1'b0);
    rst_n = 1'b1; id_ready = 1'b1;
    step(1);
    check("t1_first_valid", {31'd0, id_valid}, 32'd1);
    check("t1_first_pc", id_pc, 32'h0);
    step(3);
    rst_n = 1'b0; id_ready = 1'b0;
    step(1);
    check("t1_rst_valid", {31'd0, id_valid}, 32'd0);

    // Backpressure: queue fills, PC holds, release in order
    rst_n = 1'b1;
    step(5);
    check("t2_imem_hold", imem_pc, 32'h8);
    check("t2_valid", {31'd0, id_valid}, 32'd1);
    check("t2_head_pc", id_pc, 32'h0);
    expect_entry(32'h0, NOP,           32'h4, 1'b0);
    expect_entry(32'h4, 32'h0040_0093, 32'h8, 1'b0);
    expect_entry(32'h8, 32'h0010_0113, 32'hC, 1'b0);
    id_ready = 1'b1;
    step(3);

    // Redirect with two entries queued
    check("t3_head_pc", id_pc, 32'hC);
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_003C;
    step(1);
    check("t3_bubble_valid", {31'd0, id_valid}, 32'd0);
    check("t3_imem_pc", imem_pc, 32'h3C);
    redirect_valid = 1'b0; id_ready = 1'b1;
    expect_entry(32'h3C, 32'h4047_5793, 32'h40, 1'b0);
    step(1);
    check("t3_target_pc", id_pc, 32'h3C);
    check("t3_target_instr", id_instr, 32'h4047_5793);

    // Redirect to the top of the address space; PC wraps to zero
    expect_entry(32'hFFFF_FFFC, 32'h3FFF_FFFC, 32'h0, 1'b0);
    expect_entry(32'h0000_0000, NOP,           32'h4, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    check("t4_bubble_valid", {31'd0, id_valid}, 32'd0);
    check("t4_imem_pc", imem_pc, 32'hFFFF_FFFC);
    step(3);

    // Reset mid-stream with a full queue
    id_ready = 1'b0;
    step(2);
    check("t5_full_valid", {31'd0, id_valid}, 32'd1);
    check("t5_full_head", id_pc, 32'h4);
    check("t5_full_imem_pc", imem_pc, 32'hC);
    rst_n = 1'b0;
    step(1);
    check("t5_rst_valid", {31'd0, id_valid}, 32'd0);
    check("t5_rst_imem_pc", imem_pc, 32'h0);
    check("t5_rst_instr", id_instr, NOP);
    expect_entry(32'h0, NOP,           32'h4, 1'b0);
    expect_entry(32'h4, 32'h0040_0093, 32'h8, 1'b0);
    rst_n = 1'b1; id_ready = 1'b1;
    step(2);

    // Misaligned redirect
`ifdef IFETCH_MISALIGN_TRAP_EN
    expect_entry(32'h6, NOP, 32'hA, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
    step(1);
    redirect_valid = 1'b0;
    check("t6_imem_pc", imem_pc, 32'h6);
    step(3);
    check("t6_halt_valid", {31'd0, id_valid}, 32'd0);
    check("t6_halt_imem_pc", imem_pc, 32'h6);
    expect_entry(32'h10, 32'hC000_0010, 32'h14, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
    step(1);
    redirect_valid = 1'b0;
    step(2);
    id_ready = 1'b0;
`else
    expect_entry(32'h4, 32'h0040_0093, 32'h8, 1'b0);
    expect_entry(32'h8, 32'h0010_0113, 32'hC, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006;
    step(1);
    redirect_valid = 1'b0;
    check("t6_imem_pc", imem_pc, 32'h4);
    step(3);
    id_ready = 1'b0;
`endif
    step(2);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
